// File: rtl/rs_station_if.sv
// Dispatch, broadcast, issue and status bundle for the reservation station.
// The slave modport is the station's view; master is the driver's view.
interface rs_station_if #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2
);
  logic                      rdy;
  logic                      flush;
  logic                      disp_valid;
  logic                      disp_ready;
  logic [OP_W-1:0]           disp_op;
  logic [DATA_W-1:0]         disp_pc;
  logic [DATA_W-1:0]         disp_imm;
  logic [TAG_W-1:0]          disp_tag;
  logic [DATA_W-1:0]         disp_vj;
  logic [DATA_W-1:0]         disp_vk;
  logic [TAG_W-1:0]          disp_qj;
  logic [TAG_W-1:0]          disp_qk;
  logic                      disp_wj;
  logic                      disp_wk;
  logic [NUM_CDB-1:0]        cdb_valid;
  logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
  logic [NUM_CDB*DATA_W-1:0] cdb_data;
  logic                      iss_valid;
  logic                      iss_ready;
  logic [OP_W-1:0]           iss_op;
  logic [DATA_W-1:0]         iss_pc;
  logic [DATA_W-1:0]         iss_imm;
  logic [DATA_W-1:0]         iss_vj;
  logic [DATA_W-1:0]         iss_vk;
  logic [TAG_W-1:0]          iss_tag;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                      full;

  modport slave (
    input  rdy, flush, disp_valid, disp_op, disp_pc, disp_imm, disp_tag,
           disp_vj, disp_vk, disp_qj, disp_qk, disp_wj, disp_wk,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    output disp_ready, iss_valid, iss_op, iss_pc, iss_imm, iss_vj, iss_vk,
           iss_tag, count, full
  );

  modport master (
    output rdy, flush, disp_valid, disp_op, disp_pc, disp_imm, disp_tag,
           disp_vj, disp_vk, disp_qj, disp_qk, disp_wj, disp_wk,
           cdb_valid, cdb_tag, cdb_data, iss_ready,
    input  disp_ready, iss_valid, iss_op, iss_pc, iss_imm, iss_vj, iss_vk,
           iss_tag, count, full
  );
endinterface

// File: rtl/rs_station.sv
// Reservation station: holds dispatched ops until operands arrive over the
// CDB, then issues the oldest ready entry. Relative age kept in a matrix.
module rs_station #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2
) (
  input logic         clk,
  input logic         rst,
  rs_station_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  valid_reg, wj_reg, wk_reg;
  logic [OP_W-1:0]   op_reg  [DEPTH];
  logic [DATA_W-1:0] pc_reg  [DEPTH];
  logic [DATA_W-1:0] imm_reg [DEPTH];
  logic [DATA_W-1:0] vj_reg  [DEPTH];
  logic [DATA_W-1:0] vk_reg  [DEPTH];
  logic [TAG_W-1:0]  tag_reg [DEPTH];
  logic [TAG_W-1:0]  qj_reg  [DEPTH];
  logic [TAG_W-1:0]  qk_reg  [DEPTH];
  // older_reg[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0]  older_reg [DEPTH];
  logic [DEPTH-1:0]  older_col [DEPTH];
  logic [CNT_W-1:0]  count_reg;

  logic [DEPTH-1:0]  ready, sel_vec;
  logic [DATA_W:0]   wake_j [DEPTH];
  logic [DATA_W:0]   wake_k [DEPTH];
  logic [DATA_W:0]   byp_j, byp_k;
  logic [IDX_W-1:0]  sel_idx, free_idx;
  logic              full, iss_valid, disp_fire, iss_fire;

  // Returns {hit, data}; the lowest matching channel wins.
  function automatic logic [DATA_W:0] snoop(
    input logic [TAG_W-1:0]          q,
    input logic [NUM_CDB-1:0]        v,
    input logic [NUM_CDB*TAG_W-1:0]  t,
    input logic [NUM_CDB*DATA_W-1:0] d
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (v[c] && t[c*TAG_W +: TAG_W] == q) r = {1'b1, d[c*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      for (genvar gj = 0; gj < DEPTH; gj++) begin : g_col
        assign older_col[gi][gj] = older_reg[gj][gi];
      end
      assign ready[gi]   = valid_reg[gi] & ~wj_reg[gi] & ~wk_reg[gi];
      assign sel_vec[gi] = ready[gi] && ((ready & older_col[gi]) == '0);
      assign wake_j[gi]  = snoop(qj_reg[gi], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      assign wake_k[gi]  = snoop(qk_reg[gi], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end
  endgenerate

  assign byp_j = snoop(bus.disp_qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  assign byp_k = snoop(bus.disp_qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

  always_comb begin
    sel_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sel_vec[i])    sel_idx  = IDX_W'(i);
      if (!valid_reg[i]) free_idx = IDX_W'(i);
    end
  end

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign iss_valid = |ready;
  assign disp_fire = bus.disp_valid && !full && bus.rdy && !bus.flush;
  assign iss_fire  = iss_valid && bus.iss_ready && bus.rdy && !bus.flush;

  assign bus.disp_ready = !full;
  assign bus.full       = full;
  assign bus.count      = count_reg;
  assign bus.iss_valid  = iss_valid;
  assign bus.iss_op     = iss_valid ? op_reg[sel_idx]  : '0;
  assign bus.iss_pc     = iss_valid ? pc_reg[sel_idx]  : '0;
  assign bus.iss_imm    = iss_valid ? imm_reg[sel_idx] : '0;
  assign bus.iss_vj     = iss_valid ? vj_reg[sel_idx]  : '0;
  assign bus.iss_vk     = iss_valid ? vk_reg[sel_idx]  : '0;
  assign bus.iss_tag    = iss_valid ? tag_reg[sel_idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= '0;
      wj_reg    <= '0;
      wk_reg    <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) older_reg[i] <= '0;
    end else if (bus.rdy) begin
      if (bus.flush) begin
        valid_reg <= '0;
        count_reg <= '0;
        for (int i = 0; i < DEPTH; i++) older_reg[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_reg[i] && wj_reg[i] && wake_j[i][DATA_W]) begin
            wj_reg[i] <= 1'b0;
            vj_reg[i] <= wake_j[i][DATA_W-1:0];
          end
          if (valid_reg[i] && wk_reg[i] && wake_k[i][DATA_W]) begin
            wk_reg[i] <= 1'b0;
            vk_reg[i] <= wake_k[i][DATA_W-1:0];
          end
        end
        if (iss_fire) valid_reg[sel_idx] <= 1'b0;
        if (disp_fire) begin
          valid_reg[free_idx] <= 1'b1;
          op_reg[free_idx]    <= bus.disp_op;
          pc_reg[free_idx]    <= bus.disp_pc;
          imm_reg[free_idx]   <= bus.disp_imm;
          tag_reg[free_idx]   <= bus.disp_tag;
          qj_reg[free_idx]    <= bus.disp_qj;
          qk_reg[free_idx]    <= bus.disp_qk;
          wj_reg[free_idx]    <= bus.disp_wj && !byp_j[DATA_W];
          wk_reg[free_idx]    <= bus.disp_wk && !byp_k[DATA_W];
          vj_reg[free_idx]    <= (bus.disp_wj && byp_j[DATA_W]) ? byp_j[DATA_W-1:0] : bus.disp_vj;
          vk_reg[free_idx]    <= (bus.disp_wk && byp_k[DATA_W]) ? byp_k[DATA_W-1:0] : bus.disp_vk;
          // Newcomer is younger than every occupied entry; stale bits of
          // freed slots are rewritten when those slots are reallocated.
          older_reg[free_idx] <= '0;
          for (int j = 0; j < DEPTH; j++) older_reg[j][free_idx] <= valid_reg[j];
        end
        if (disp_fire && !iss_fire)      count_reg <= count_reg + CNT_W'(1);
        else if (!disp_fire && iss_fire) count_reg <= count_reg - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed scenarios plus random traffic, all checked
// against a dispatch-ordered queue model of the station.
module tb_rs_station;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;
  localparam int NUM_CDB = 2;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] pc, imm, vj, vk;
    logic [TAG_W-1:0]  tag, qj, qk;
    logic              wj, wk;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  ent_t mq[$];
  logic              cv [NUM_CDB];
  logic [TAG_W-1:0]  ct [NUM_CDB];
  logic [DATA_W-1:0] cd [NUM_CDB];

  rs_station_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W),
                  .NUM_CDB(NUM_CDB)) bus ();

  rs_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W),
               .NUM_CDB(NUM_CDB)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic bit model_snoop(input logic [TAG_W-1:0] q, output logic [DATA_W-1:0] d);
    d = '0;
    for (int c = 0; c < NUM_CDB; c++) begin
      if (cv[c] && ct[c] == q) begin
        d = cd[c];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic set_cdb(input int c, input logic v, input logic [TAG_W-1:0] t,
                         input logic [DATA_W-1:0] d);
    cv[c] = v;
    ct[c] = t;
    cd[c] = d;
    for (int k = 0; k < NUM_CDB; k++) begin
      bus.cdb_valid[k]                  = cv[k];
      bus.cdb_tag[k*TAG_W +: TAG_W]     = ct[k];
      bus.cdb_data[k*DATA_W +: DATA_W]  = cd[k];
    end
  endtask

  task automatic disp(input logic [TAG_W-1:0] tag, input logic wj, input logic [TAG_W-1:0] qj,
                      input logic wk, input logic [TAG_W-1:0] qk);
    bus.disp_valid = 1'b1;
    bus.disp_op    = OP_W'($urandom);
    bus.disp_pc    = $urandom;
    bus.disp_imm   = $urandom;
    bus.disp_vj    = $urandom;
    bus.disp_vk    = $urandom;
    bus.disp_tag   = tag;
    bus.disp_wj    = wj;
    bus.disp_qj    = qj;
    bus.disp_wk    = wk;
    bus.disp_qk    = qk;
  endtask

  // Compares outputs with the model, then advances model and DUT one edge.
  task automatic cycle(input bit check);
    int sel;
    ent_t e;
    ent_t nq[$];
    logic [DATA_W-1:0] d;
    #1;
    sel = -1;
    foreach (mq[i]) if (sel < 0 && !mq[i].wj && !mq[i].wk) sel = i;
    if (check) begin
      e = '{default: 0};
      if (sel >= 0) e = mq[sel];
      chk("count",      64'(bus.count),      64'(mq.size()));
      chk("full",       64'(bus.full),       64'(mq.size() == DEPTH));
      chk("disp_ready", 64'(bus.disp_ready), 64'(mq.size() < DEPTH));
      chk("iss_valid",  64'(bus.iss_valid),  64'(sel >= 0));
      chk("iss_tag",    64'(bus.iss_tag),    64'(e.tag));
      chk("iss_op",     64'(bus.iss_op),     64'(e.op));
      chk("iss_pc",     64'(bus.iss_pc),     64'(e.pc));
      chk("iss_imm",    64'(bus.iss_imm),    64'(e.imm));
      chk("iss_vj",     64'(bus.iss_vj),     64'(e.vj));
      chk("iss_vk",     64'(bus.iss_vk),     64'(e.vk));
    end
    nq = mq;
    if (!rst) begin
      nq.delete();
    end else if (bus.rdy) begin
      if (bus.flush) begin
        nq.delete();
      end else begin
        foreach (nq[i]) begin
          if (nq[i].wj && model_snoop(nq[i].qj, d)) begin nq[i].wj = 1'b0; nq[i].vj = d; end
          if (nq[i].wk && model_snoop(nq[i].qk, d)) begin nq[i].wk = 1'b0; nq[i].vk = d; end
        end
        if (sel >= 0 && bus.iss_ready) nq.delete(sel);
        if (bus.disp_valid && mq.size() < DEPTH) begin
          e.op = bus.disp_op;   e.pc = bus.disp_pc;   e.imm = bus.disp_imm;
          e.tag = bus.disp_tag; e.qj = bus.disp_qj;   e.qk = bus.disp_qk;
          e.vj = bus.disp_vj;   e.vk = bus.disp_vk;
          e.wj = bus.disp_wj;   e.wk = bus.disp_wk;
          if (e.wj && model_snoop(e.qj, d)) begin e.wj = 1'b0; e.vj = d; end
          if (e.wk && model_snoop(e.qk, d)) begin e.wk = 1'b0; e.vk = d; end
          nq.push_back(e);
        end
      end
    end
    @(posedge clk);
    mq = nq;
    #1;
  endtask

  initial begin
    bus.rdy = 1'b1;
    bus.flush = 1'b0;
    bus.iss_ready = 1'b0;
    bus.cdb_valid = '0;
    bus.cdb_tag = '0;
    bus.cdb_data = '0;
    for (int c = 0; c < NUM_CDB; c++) set_cdb(c, 1'b0, '0, '0);

    // Reset with a dispatch request pending: nothing may be captured
    rst = 1'b0;
    disp(5'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    cycle(1'b0);
    cycle(1'b0);
    rst = 1'b1;
    bus.disp_valid = 1'b0;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    cycle(1'b1);

    // Age order: 3 and 7 wait on tag 12, 9 ready; expected issue 9, 3, 7
    bus.iss_ready = 1'b1;
    disp(5'd3, 1'b1, 5'd12, 1'b0, 5'd0); cycle(1'b1);
    disp(5'd7, 1'b1, 5'd12, 1'b0, 5'd0); cycle(1'b1);
    disp(5'd9, 1'b0, 5'd0, 1'b0, 5'd0);  cycle(1'b1);
    bus.disp_valid = 1'b0;
    chk("age_first", 64'(bus.iss_tag), 64'd9);
    set_cdb(1, 1'b1, 5'd12, 32'h55);
    cycle(1'b1);
    set_cdb(1, 1'b0, '0, '0);
    chk("age_second", 64'(bus.iss_tag), 64'd3);
    chk("age_second_vj", 64'(bus.iss_vj), 64'h55);
    cycle(1'b1);
    chk("age_third", 64'(bus.iss_tag), 64'd7);
    chk("age_third_vj", 64'(bus.iss_vj), 64'h55);
    cycle(1'b1);
    cycle(1'b1);

    // Full / backpressure, then a flush that drops its concurrent dispatch
    bus.iss_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp(TAG_W'(i), 1'b1, TAG_W'(20 + i), 1'b0, 5'd0);
      cycle(1'b1);
    end
    disp(5'd30, 1'b0, 5'd0, 1'b0, 5'd0);
    cycle(1'b1);
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_flag", 64'(bus.full), 64'd1);
    chk("full_disp_ready", 64'(bus.disp_ready), 64'd0);
    bus.flush = 1'b1;
    cycle(1'b1);
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    chk("flush_count", 64'(bus.count), 64'd0);

    // Dispatch bypass on j, later wakeup on k with both channels matching
    bus.iss_ready = 1'b1;
    disp(5'd1, 1'b1, 5'd5, 1'b1, 5'd6);
    set_cdb(0, 1'b1, 5'd5, 32'hA);
    set_cdb(1, 1'b1, 5'd8, 32'hC);
    cycle(1'b1);
    bus.disp_valid = 1'b0;
    chk("byp_wait_k", 64'(bus.iss_valid), 64'd0);
    set_cdb(0, 1'b1, 5'd6, 32'hB);
    set_cdb(1, 1'b1, 5'd6, 32'hD);
    cycle(1'b1);
    set_cdb(0, 1'b0, '0, '0);
    set_cdb(1, 1'b0, '0, '0);
    chk("byp_valid", 64'(bus.iss_valid), 64'd1);
    chk("byp_vj", 64'(bus.iss_vj), 64'hA);
    chk("byp_vk", 64'(bus.iss_vk), 64'hB);
    cycle(1'b1);

    // Stall with three ready entries, then flush
    bus.iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(TAG_W'(10 + i), 1'b0, 5'd0, 1'b0, 5'd0);
      cycle(1'b1);
    end
    bus.rdy = 1'b0;
    bus.iss_ready = 1'b1;
    cycle(1'b1);
    cycle(1'b1);
    chk("stall_count", 64'(bus.count), 64'd3);
    bus.rdy = 1'b1;
    bus.flush = 1'b1;
    cycle(1'b1);
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    chk("stall_flush_count", 64'(bus.count), 64'd0);
    chk("stall_flush_iss", 64'(bus.iss_valid), 64'd0);

    // Random interleaving of dispatch, wakeup, issue, stall and flush
    for (int n = 0; n < 300; n++) begin
      disp(TAG_W'($urandom), 1'($urandom), TAG_W'($urandom_range(0, 7)),
           1'($urandom), TAG_W'($urandom_range(0, 7)));
      bus.disp_valid = ($urandom_range(0, 9) < 6);
      for (int c = 0; c < NUM_CDB; c++)
        set_cdb(c, 1'($urandom), TAG_W'($urandom_range(0, 7)), $urandom);
      bus.iss_ready = 1'($urandom);
      bus.rdy   = ($urandom_range(0, 9) != 0);
      bus.flush = ($urandom_range(0, 49) == 0);
      cycle(1'b1);
    end
    bus.disp_valid = 1'b0;
    bus.flush = 1'b0;
    bus.rdy = 1'b1;
    cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
